game_ctrl: RTL and testbench
============================

# game_ctrl

Top-level game sequencer for the typing game. It decodes menu keystrokes from the PS/2 keyboard decoder and drives `state`, `mode` and `value` into the typing/counting stage. It runs the 3-2-1 pre-game countdown and consumes that stage's `finish` and `wpm` outputs to end a round and keep a per-mode best-WPM record.

## Interface
- `TICK_DIV`, default 100_000_000: clk cycles per countdown second.
- `clk` input 1: system clock; one clock domain.
- `rst` input 1: synchronous, active-high reset.
- `key_down` input 128: held-key bitmap from the keyboard decoder.
- `last_change` input 9: code of the most recently changed key; bit 8 set marks an E0-extended key.
- `key_valid` input 1: one-cycle strobe qualifying `last_change`.
- `finish` input 1: round-complete flag from the counting stage.
- `wpm` input 10: current WPM from the counting stage.
- `state` output 2: SELECT=0, COUNTDOWN=1, INGAME=2, FINISH=3.
- `mode` output 1: 0 = timed round (`value` is seconds); 1 = word-count round (`value` is words).
- `value` output 7: round length.
- `cd_sec` output 2: countdown digit. It is 3, 2 or 1 in COUNTDOWN and 0 otherwise.
- `best_wpm` output 10: best WPM recorded for the current `mode`.
- `new_record` output 1: high in FINISH when the round just ended set a new best.

## Operation
- Press event: `key_valid && key_down[last_change]`. Key releases are ignored.
- Key codes:
  - ENTER = 9'h05A
  - ESC = 9'h076
  - M = 9'h03A
  - UP = 9'h175
  - DOWN = 9'h172
- Value table, indexed by `idx[1:0]`:
  - mode 0: {15, 30, 45, 60}
  - mode 1: {10, 25, 50, 100}
  - `value` = table[mode][idx]; it is a registered output.
- SELECT:
  - M toggles `mode`; `idx` is kept.
  - UP increments `idx` and saturates at 3.
  - DOWN decrements `idx` and saturates at 0.
  - ENTER moves to COUNTDOWN.
- COUNTDOWN:
  - `cd_sec` starts at 3 and decrements on each tick.
  - The tick that would take it past 1 moves to INGAME instead.
  - Menu keys are ignored.
- INGAME:
  - `finish`=1 moves to FINISH.
  - In the same cycle, `best[mode]` takes `wpm` if `wpm > best[mode]`, and `new_record` takes the value of that comparison.
- FINISH:
  - `mode`, `value` and `best` are held.
  - ENTER moves to SELECT and clears `new_record`.
- ESC in any state except SELECT moves to SELECT and clears `new_record`. ESC has priority over ENTER and over `finish`; when ESC wins over `finish`, `best` is not updated.
- Best records:
  - Two 10-bit registers, one per mode.
  - Comparison is strict (`wpm > best`), so a tie is not a record.
  - `best_wpm` = best[mode], combinational select of registered values.
- Prescaler:
  - Counts 0..TICK_DIV-1, but only in COUNTDOWN; it is held at 0 in every other state.
  - Tick = prescaler at TICK_DIV-1; the prescaler wraps to 0 on the tick.
  - The prescaler clears when COUNTDOWN is entered, so the first second is always full length.
  - Width = clog2(TICK_DIV).

## Timing
- Reset values:
  - `state` = SELECT
  - `mode` = 0
  - `idx` = 1, so `value` = 30
  - `cd_sec` = 0
  - best[0] = best[1] = 0, so `best_wpm` = 0
  - `new_record` = 0
  - prescaler = 0
- A reset mid-round returns every output to these values at the next edge.
- All transitions take effect on the clock edge after the qualifying cycle. `mode` and `value` change on the edge after M/UP/DOWN.
- ENTER is sampled in cycle T. Then:
  - At T+1: `state`=COUNTDOWN, `cd_sec`=3.
  - At T+1+TICK_DIV: `cd_sec`=2.
  - At T+1+2·TICK_DIV: `cd_sec`=1.
  - At T+1+3·TICK_DIV: `state`=INGAME, `cd_sec`=0.
- `finish`=1 in cycle F while INGAME → at F+1, `state`=FINISH and `best`/`new_record` are updated.
- `finish` is ignored outside INGAME.
- `mode` and `value` are frozen outside SELECT. The downstream stage may therefore sample them at any cycle in COUNTDOWN or INGAME.
- Only one press can occur per cycle, because `last_change` is single-valued. No other simultaneous key events exist.

## Test plan
- Reset, then UP ×3, then M, then DOWN ×5 → after UP: `value`=60 (saturated). After M: `mode`=1, `value`=100. After DOWN: `value`=10 (`idx` saturated at 0).
- TICK_DIV=4; ENTER in cycle 10 → cycle 11 `state`=1, `cd_sec`=3; cycle 15 `cd_sec`=2; cycle 19 `cd_sec`=1; cycle 23 `state`=2, `cd_sec`=0.
- Round 1 in INGAME: `wpm`=42, pulse `finish` → `state`=3, `best_wpm`=42, `new_record`=1. ENTER → SELECT, `new_record`=0.
- Round 2, same mode: finish with `wpm`=42 → `new_record`=0, `best_wpm`=42. Toggle M → `best_wpm`=0.
- ESC in COUNTDOWN at `cd_sec`=2 → next cycle `state`=0, `cd_sec`=0. Re-enter COUNTDOWN → `cd_sec`=3 with a full TICK_DIV period before the first decrement.
- `finish`=1 and ESC press in the same INGAME cycle → `state`=0 and `best` unchanged. Assert `rst` mid-INGAME → all outputs return to reset values, including `value`=30 and `best_wpm`=0.

Source files
------------

// File: rtl/game_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : game_ctrl_if
//  Description : Bundles the keyboard, counting-stage and game-status
//                signals of the typing-game sequencer. The master modport
//                is the environment side; the slave modport is the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface game_ctrl_if;
    logic [127:0] key_down;
    logic [8:0]   last_change;
    logic         key_valid;
    logic         finish;
    logic [9:0]   wpm;
    logic [1:0]   state;
    logic         mode;
    logic [6:0]   value;
    logic [1:0]   cd_sec;
    logic [9:0]   best_wpm;
    logic         new_record;

    modport master (
        output key_down, last_change, key_valid, finish, wpm,
        input  state, mode, value, cd_sec, best_wpm, new_record
    );

    modport slave (
        input  key_down, last_change, key_valid, finish, wpm,
        output state, mode, value, cd_sec, best_wpm, new_record
    );
endinterface
`default_nettype wire

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : game_ctrl
//  Description : Typing-game sequencer. Menu selection of mode/round length,
//                3-2-1 countdown, round end on finish, per-mode best WPM.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_ctrl #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    game_ctrl_if.slave  bus_if
);
    localparam logic [1:0] S_SELECT    = 2'd0;
    localparam logic [1:0] S_COUNTDOWN = 2'd1;
    localparam logic [1:0] S_INGAME    = 2'd2;
    localparam logic [1:0] S_FINISH    = 2'd3;

    localparam logic [8:0] KEY_ENTER = 9'h05A;
    localparam logic [8:0] KEY_ESC   = 9'h076;
    localparam logic [8:0] KEY_M     = 9'h03A;
    localparam logic [8:0] KEY_UP    = 9'h175;
    localparam logic [8:0] KEY_DOWN  = 9'h172;

    // A width of at least one bit keeps TICK_DIV=1 legal.
    localparam int            CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    // Round length for a given mode and menu index.
    function automatic logic [6:0] f_value(input logic m, input logic [1:0] i);
        case ({m, i})
            3'b000:  f_value = 7'd15;
            3'b001:  f_value = 7'd30;
            3'b010:  f_value = 7'd45;
            3'b011:  f_value = 7'd60;
            3'b100:  f_value = 7'd10;
            3'b101:  f_value = 7'd25;
            3'b110:  f_value = 7'd50;
            default: f_value = 7'd100;
        endcase
    endfunction

    logic [1:0]    state_q, state_d;
    logic          mode_q, mode_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    value_q, value_d;
    logic [1:0]    cd_q, cd_d;
    logic [CW-1:0] presc_q, presc_d;
    logic [9:0]    best0_q, best0_d;
    logic [9:0]    best1_q, best1_d;
    logic          nr_q, nr_d;

    logic       press, is_enter, is_esc, is_m, is_up, is_down, tick;
    logic       record_en, beats;
    logic [9:0] cur_best;

    // The held-key bitmap covers only the low 7 bits of the code, so an
    // extended key shares its bitmap slot with its non-extended twin.
    assign press    = bus_if.key_valid && bus_if.key_down[bus_if.last_change[6:0]];
    assign is_enter = press && (bus_if.last_change == KEY_ENTER);
    assign is_esc   = press && (bus_if.last_change == KEY_ESC);
    assign is_m     = press && (bus_if.last_change == KEY_M);
    assign is_up    = press && (bus_if.last_change == KEY_UP);
    assign is_down  = press && (bus_if.last_change == KEY_DOWN);
    assign tick     = (presc_q == TICK_LAST);
    assign cur_best = mode_q ? best1_q : best0_q;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_SELECT;
            mode_q  <= 1'b0;
            idx_q   <= 2'd1;
            value_q <= 7'd30;
            cd_q    <= 2'd0;
            presc_q <= '0;
            best0_q <= 10'd0;
            best1_q <= 10'd0;
            nr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            value_q <= value_d;
            cd_q    <= cd_d;
            presc_q <= presc_d;
            best0_q <= best0_d;
            best1_q <= best1_d;
            nr_q    <= nr_d;
        end
    end

    // Next state; ESC outranks ENTER and finish in every non-menu state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_SELECT:    if (is_enter) state_d = S_COUNTDOWN;
            S_COUNTDOWN: begin
                if (is_esc)                        state_d = S_SELECT;
                else if (tick && (cd_q == 2'd1))   state_d = S_INGAME;
            end
            S_INGAME: begin
                if (is_esc)                state_d = S_SELECT;
                else if (bus_if.finish)    state_d = S_FINISH;
            end
            S_FINISH:    if (is_esc || is_enter) state_d = S_SELECT;
            default:     state_d = S_SELECT;
        endcase
    end

    // Menu, countdown, prescaler and best-record next values.
    always_comb begin
        mode_d  = mode_q;
        idx_d   = idx_q;
        cd_d    = 2'd0;
        presc_d = '0;
        best0_d = best0_q;
        best1_d = best1_q;
        nr_d    = nr_q;

        if (state_q == S_SELECT) begin
            if (is_m)                         mode_d = ~mode_q;
            if (is_up   && (idx_q != 2'd3))   idx_d  = idx_q + 2'd1;
            if (is_down && (idx_q != 2'd0))   idx_d  = idx_q - 2'd1;
        end
        // Outside SELECT mode/idx are held, so value stays frozen too.
        value_d = f_value(mode_d, idx_d);

        if (state_d == S_COUNTDOWN) begin
            if (state_q != S_COUNTDOWN) cd_d = 2'd3;
            else if (tick)              cd_d = cd_q - 2'd1;
            else                        cd_d = cd_q;
        end

        // Prescaler restarts from zero on every entry into COUNTDOWN.
        if ((state_q == S_COUNTDOWN) && (state_d == S_COUNTDOWN) && !tick)
            presc_d = presc_q + 1'b1;

        record_en = (state_q == S_INGAME) && bus_if.finish && !is_esc;
        beats     = (bus_if.wpm > cur_best);
        if (record_en) begin
            nr_d = beats;
            if (beats) begin
                if (mode_q) best1_d = bus_if.wpm;
                else        best0_d = bus_if.wpm;
            end
        end
        if ((state_d == S_SELECT) && (state_q != S_SELECT)) nr_d = 1'b0;
    end

    // Drive the status outputs from registered state.
    always_comb begin
        bus_if.state      = state_q;
        bus_if.mode       = mode_q;
        bus_if.value      = value_q;
        bus_if.cd_sec     = cd_q;
        bus_if.best_wpm   = cur_best;
        bus_if.new_record = nr_q;
    end
endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_ctrl
//  Description : Self-checking bench for game_ctrl (TICK_DIV = 4). Menu
//                vectors come from a table; countdown, round end, ESC and
//                reset corner cases are hand-written sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_ctrl;
    localparam int TD = 4;

    localparam logic [8:0] K_NONE  = 9'h000;
    localparam logic [8:0] K_ENTER = 9'h05A;
    localparam logic [8:0] K_ESC   = 9'h076;
    localparam logic [8:0] K_M     = 9'h03A;
    localparam logic [8:0] K_UP    = 9'h175;
    localparam logic [8:0] K_DOWN  = 9'h172;

    typedef struct {
        logic       rst;
        logic [8:0] code;
        logic       kv;
        logic       dn;
        logic       fin;
        logic [9:0] wpm;
        logic [1:0] st;
        logic       md;
        logic [6:0] val;
        logic [1:0] cd;
        logic [9:0] best;
        logic       nr;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t exp_q[$];
    vec_t menu[$];

    game_ctrl_if bus_if();

    game_ctrl #(.TICK_DIV(TD)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus_if)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [8:0] code, input logic kv,
                                input logic dn, input logic fin, input logic [9:0] wpm,
                                input logic [1:0] st, input logic md, input logic [6:0] val,
                                input logic [1:0] cd, input logic [9:0] best, input logic nr,
                                input string name);
        vec_t v;
        v.rst = r; v.code = code; v.kv = kv; v.dn = dn; v.fin = fin; v.wpm = wpm;
        v.st = st; v.md = md; v.val = val; v.cd = cd; v.best = best; v.nr = nr;
        v.name = name;
        return v;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, check after the edge.
    task automatic apply(input vec_t v);
        vec_t e;
        rst                = v.rst;
        bus_if.key_down    = '0;
        if (v.dn) bus_if.key_down[v.code[6:0]] = 1'b1;
        bus_if.last_change = v.code;
        bus_if.key_valid   = v.kv;
        bus_if.finish      = v.fin;
        bus_if.wpm         = v.wpm;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_tests++;
        if ({bus_if.state, bus_if.mode, bus_if.value, bus_if.cd_sec, bus_if.best_wpm, bus_if.new_record}
            !== {e.st, e.md, e.val, e.cd, e.best, e.nr}) begin
            n_fail++;
            $display("FAIL %s: got st=%0d md=%0d val=%0d cd=%0d best=%0d nr=%0d, want st=%0d md=%0d val=%0d cd=%0d best=%0d nr=%0d",
                     e.name, bus_if.state, bus_if.mode, bus_if.value, bus_if.cd_sec,
                     bus_if.best_wpm, bus_if.new_record,
                     e.st, e.md, e.val, e.cd, e.best, e.nr);
        end
        bus_if.key_valid = 1'b0;
        bus_if.finish    = 1'b0;
    endtask

    task automatic press(input logic [8:0] code, input logic [1:0] st, input logic md,
                         input logic [6:0] val, input logic [1:0] cd, input logic [9:0] best,
                         input logic nr, input string name);
        apply(mk(1'b0, code, 1'b1, 1'b1, 1'b0, 10'd0, st, md, val, cd, best, nr, name));
    endtask

    // n cycles after ENTER; optionally presses UP and M mid-countdown.
    task automatic countdown(input int n, input logic md, input logic [6:0] val,
                             input logic [9:0] best, input bit with_keys);
        for (int i = 1; i <= n; i++) begin
            logic [1:0] ecd;
            logic [1:0] est;
            logic [8:0] code;
            logic       kv;
            ecd  = (i < TD) ? 2'd3 : (i < 2*TD) ? 2'd2 : (i < 3*TD) ? 2'd1 : 2'd0;
            est  = (i < 3*TD) ? 2'd1 : 2'd2;
            kv   = with_keys && (i == 1 || i == 5);
            code = (with_keys && i == 1) ? K_UP : (with_keys && i == 5) ? K_M : K_NONE;
            apply(mk(1'b0, code, kv, kv, 1'b0, 10'd0, est, md, val, ecd, best, 1'b0, "countdown"));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.key_down    = '0;
        bus_if.last_change = '0;
        bus_if.key_valid   = 1'b0;
        bus_if.finish      = 1'b0;
        bus_if.wpm         = '0;
        rst                = 1'b1;

        menu.push_back(mk(0, K_UP,   1, 1, 0, 0, 0, 0, 7'd45,  0, 0, 0, "up1"));
        menu.push_back(mk(0, K_UP,   1, 1, 0, 0, 0, 0, 7'd60,  0, 0, 0, "up2"));
        menu.push_back(mk(0, K_UP,   1, 1, 0, 0, 0, 0, 7'd60,  0, 0, 0, "up_sat"));
        menu.push_back(mk(0, K_M,    1, 1, 0, 0, 0, 1, 7'd100, 0, 0, 0, "mode_toggle"));
        menu.push_back(mk(0, K_DOWN, 1, 1, 0, 0, 0, 1, 7'd50,  0, 0, 0, "down1"));
        menu.push_back(mk(0, K_DOWN, 1, 1, 0, 0, 0, 1, 7'd25,  0, 0, 0, "down2"));
        menu.push_back(mk(0, K_DOWN, 1, 1, 0, 0, 0, 1, 7'd10,  0, 0, 0, "down3"));
        menu.push_back(mk(0, K_DOWN, 1, 1, 0, 0, 0, 1, 7'd10,  0, 0, 0, "down_sat4"));
        menu.push_back(mk(0, K_DOWN, 1, 1, 0, 0, 0, 1, 7'd10,  0, 0, 0, "down_sat5"));
        menu.push_back(mk(0, K_M,    1, 1, 0, 0, 0, 0, 7'd15,  0, 0, 0, "mode_back"));
        menu.push_back(mk(0, K_UP,   1, 0, 0, 0, 0, 0, 7'd15,  0, 0, 0, "release_ignored"));
        menu.push_back(mk(0, K_UP,   1, 1, 0, 0, 0, 0, 7'd30,  0, 0, 0, "up_to_30"));
        menu.push_back(mk(0, K_ESC,  1, 1, 0, 0, 0, 0, 7'd30,  0, 0, 0, "esc_in_select"));

        apply(mk(1, K_NONE, 0, 0, 0, 0, 0, 0, 7'd30, 0, 0, 0, "reset"));
        apply(mk(1, K_NONE, 0, 0, 0, 0, 0, 0, 7'd30, 0, 0, 0, "reset_hold"));
        foreach (menu[i]) apply(menu[i]);

        // Round 1: countdown timing, then a new record of 42.
        press(K_ENTER, 1, 0, 7'd30, 3, 0, 0, "enter_cd3");
        countdown(3*TD, 1'b0, 7'd30, 10'd0, 1'b1);
        apply(mk(0, K_NONE, 0, 0, 0, 10'd42, 2, 0, 7'd30, 0, 0,  0, "ingame_idle"));
        apply(mk(0, K_NONE, 0, 0, 1, 10'd42, 3, 0, 7'd30, 0, 42, 1, "finish_record"));
        apply(mk(0, K_NONE, 0, 0, 1, 10'd99, 3, 0, 7'd30, 0, 42, 1, "finish_ignored"));
        press(K_UP,    3, 0, 7'd30, 0, 42, 1, "up_in_finish");
        press(K_ENTER, 0, 0, 7'd30, 0, 42, 0, "finish_enter");

        // Round 2: a tie is not a record; best is kept per mode.
        press(K_ENTER, 1, 0, 7'd30, 3, 42, 0, "enter2");
        countdown(3*TD, 1'b0, 7'd30, 10'd42, 1'b0);
        apply(mk(0, K_NONE, 0, 0, 1, 10'd42, 3, 0, 7'd30, 0, 42, 0, "tie_no_record"));
        press(K_ENTER, 0, 0, 7'd30, 0, 42, 0, "finish_enter2");
        press(K_M,     0, 1, 7'd25, 0, 0,  0, "best_mode1");
        press(K_M,     0, 0, 7'd30, 0, 42, 0, "best_mode0");

        // ESC mid-countdown, then re-entry with a full first second.
        press(K_ENTER, 1, 0, 7'd30, 3, 42, 0, "enter3");
        countdown(TD, 1'b0, 7'd30, 10'd42, 1'b0);
        press(K_ESC,   0, 0, 7'd30, 0, 42, 0, "esc_in_cd");
        press(K_ENTER, 1, 0, 7'd30, 3, 42, 0, "reenter_cd3");
        countdown(3*TD, 1'b0, 7'd30, 10'd42, 1'b0);

        // ESC beats finish: no record even with a higher wpm.
        apply(mk(0, K_ESC, 1, 1, 1, 10'd100, 0, 0, 7'd30, 0, 42, 0, "esc_vs_finish"));

        // Reset in the middle of a round.
        press(K_UP,    0, 0, 7'd45, 0, 42, 0, "up_before_rst");
        press(K_ENTER, 1, 0, 7'd45, 3, 42, 0, "enter4");
        countdown(3*TD, 1'b0, 7'd45, 10'd42, 1'b0);
        apply(mk(1, K_NONE, 0, 0, 0, 10'd0, 0, 0, 7'd30, 0, 0, 0, "rst_midgame"));
        apply(mk(0, K_NONE, 0, 0, 0, 10'd0, 0, 0, 7'd30, 0, 0, 0, "after_rst"));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
